// File: rtl/loader_pkg.sv
// Shared constants and FSM state encodings for the program loader.
package loader_pkg;

   localparam int unsigned INSTR_W       = 16;
   localparam int unsigned MAX_WORDS_DEF = 256;
   localparam int unsigned WCNT_W        = 9;
   localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_COUNT = 3'd1;
   localparam state_t ST_HI    = 3'd2;
   localparam state_t ST_LO    = 3'd3;
   localparam state_t ST_WRITE = 3'd4;
   localparam state_t ST_CHECK = 3'd5;
   localparam state_t ST_DONE  = 3'd6;
   localparam state_t ST_ERROR = 3'd7;

   // States in which the loader accepts a stream byte.
   function automatic logic state_accepts(input state_t s);
      return (s == ST_IDLE) || (s == ST_COUNT) || (s == ST_HI) ||
             (s == ST_LO) || (s == ST_CHECK);
   endfunction

   // States in which the inter-byte idle timer runs.
   function automatic logic state_timed(input state_t s);
      return (s == ST_COUNT) || (s == ST_HI) || (s == ST_LO) || (s == ST_CHECK);
   endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle counter; expired is high during the TIMEOUT_CYCLES-th consecutive
// enabled cycle without a clear. TIMEOUT_CYCLES must be at least 2.
module loader_timeout
   import loader_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             expired_q, expired_d;
   logic             restart;

   assign restart = clear || !enable;
   assign expired = expired_q;

   // Count idle cycles; flag one cycle early so the flag lines up with the last idle cycle.
   always_comb begin
      cnt_d     = cnt_q;
      expired_d = 1'b0;
      if (restart) begin
         cnt_d = '0;
      end else begin
         cnt_d     = cnt_q + CNT_W'(1);
         expired_d = (cnt_d == CNT_W'(TIMEOUT_CYCLES - 1));
      end
   end

   // Counter and flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         expired_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         expired_q <= expired_d;
      end
   end

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader: installs 16-bit words into the CPU instruction
// memory and releases the CPU only after a frame passes its checksum.
module program_loader
   import loader_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
   parameter int unsigned MAX_WORDS      = MAX_WORDS_DEF,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [7:0]         byte_data,
   input  logic               byte_valid,
   output logic               byte_ready,
   output logic               clear_code,
   output logic               getcode,
   output logic [INSTR_W-1:0] instruction_in,
   output logic               cpu_reset_n,
   output logic               load_done,
   output logic               load_error,
   output logic [WCNT_W-1:0]  words_loaded
);

   state_t              state_q, state_d;
   logic                ready_q, ready_d;
   logic                clear_code_q, clear_code_d;
   logic                getcode_q, getcode_d;
   logic [INSTR_W-1:0]  instr_q, instr_d;
   logic                run_q, run_d;
   logic                done_q, done_d;
   logic                error_q, error_d;
   logic [WCNT_W-1:0]   words_q, words_d;
   logic [WCNT_W-1:0]   remaining_q, remaining_d;
   logic [7:0]          hi_q, hi_d;
   logic [7:0]          chk_q, chk_d;

   logic                xfer;
   logic                expired;
   logic [WCNT_W-1:0]   count_n;

   assign xfer    = byte_valid && ready_q;
   // COUNT byte 0 encodes a full 256-word image.
   assign count_n = (byte_data == 8'd0) ? WCNT_W'(256) : WCNT_W'(byte_data);

   assign byte_ready     = ready_q;
   assign clear_code     = clear_code_q;
   assign getcode        = getcode_q;
   assign instruction_in = instr_q;
   assign cpu_reset_n    = run_q;
   assign load_done      = done_q;
   assign load_error     = error_q;
   assign words_loaded   = words_q;

   loader_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (xfer),
      .enable  (state_timed(state_q)),
      .expired (expired)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      clear_code_d = 1'b0;
      getcode_d    = 1'b0;
      instr_d      = instr_q;
      run_d        = run_q;
      done_d       = done_q;
      error_d      = error_q;
      words_d      = words_q;
      remaining_d  = remaining_q;
      hi_d         = hi_q;
      chk_d        = chk_q;

      case (state_q)
         ST_IDLE: begin
            if (xfer && (byte_data == SYNC_BYTE)) begin
               state_d      = ST_COUNT;
               clear_code_d = 1'b1;
               run_d        = 1'b0;
               done_d       = 1'b0;
               error_d      = 1'b0;
               words_d      = '0;
            end
         end
         ST_COUNT: begin
            if (xfer) begin
               remaining_d = count_n;
               chk_d       = byte_data;
               if (32'(count_n) > MAX_WORDS) begin
                  state_d = ST_ERROR;
                  error_d = 1'b1;
               end else begin
                  state_d = ST_HI;
               end
            end else if (expired) begin
               state_d = ST_ERROR;
               error_d = 1'b1;
            end
         end
         ST_HI: begin
            if (xfer) begin
               hi_d    = byte_data;
               chk_d   = chk_q ^ byte_data;
               state_d = ST_LO;
            end else if (expired) begin
               state_d = ST_ERROR;
               error_d = 1'b1;
            end
         end
         ST_LO: begin
            if (xfer) begin
               instr_d   = {hi_q, byte_data};
               chk_d     = chk_q ^ byte_data;
               getcode_d = 1'b1;
               state_d   = ST_WRITE;
            end else if (expired) begin
               state_d = ST_ERROR;
               error_d = 1'b1;
            end
         end
         ST_WRITE: begin
            words_d     = words_q + WCNT_W'(1);
            remaining_d = remaining_q - WCNT_W'(1);
            state_d     = (remaining_q == WCNT_W'(1)) ? ST_CHECK : ST_HI;
         end
         ST_CHECK: begin
            if (xfer) begin
               if (byte_data == chk_q) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_ERROR;
                  error_d = 1'b1;
               end
            end else if (expired) begin
               state_d = ST_ERROR;
               error_d = 1'b1;
            end
         end
         ST_DONE: begin
            run_d   = 1'b1;
            state_d = ST_IDLE;
         end
         ST_ERROR: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      ready_d = state_accepts(state_d);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         ready_q      <= 1'b0;
         clear_code_q <= 1'b0;
         getcode_q    <= 1'b0;
         instr_q      <= '0;
         run_q        <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         words_q      <= '0;
         remaining_q  <= '0;
         hi_q         <= '0;
         chk_q        <= '0;
      end else begin
         state_q      <= state_d;
         ready_q      <= ready_d;
         clear_code_q <= clear_code_d;
         getcode_q    <= getcode_d;
         instr_q      <= instr_d;
         run_q        <= run_d;
         done_q       <= done_d;
         error_q      <= error_d;
         words_q      <= words_d;
         remaining_q  <= remaining_d;
         hi_q         <= hi_d;
         chk_q        <= chk_d;
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected words are queued as frames
// are driven and popped on every getcode pulse.
module tb_program_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        byte_ready;
   logic        clear_code;
   logic        getcode;
   logic [15:0] instruction_in;
   logic        cpu_reset_n;
   logic        load_done;
   logic        load_error;
   logic [8:0]  words_loaded;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          last_clr = -100;
   int          gc_cnt = 0;
   int          clr_cnt = 0;
   logic [15:0] sb[$];
   logic [15:0] fw[0:255];

   always #5 clk = ~clk;

   program_loader #(
      .TIMEOUT_CYCLES (50)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .byte_data      (byte_data),
      .byte_valid     (byte_valid),
      .byte_ready     (byte_ready),
      .clear_code     (clear_code),
      .getcode        (getcode),
      .instruction_in (instruction_in),
      .cpu_reset_n    (cpu_reset_n),
      .load_done      (load_done),
      .load_error     (load_error),
      .words_loaded   (words_loaded)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   // Getcode monitor: pops the scoreboard and checks pulse ordering.
   always @(negedge clk) begin
      cyc++;
      if (clear_code) begin
         clr_cnt++;
         last_clr = cyc;
      end
      if (getcode) begin
         gc_cnt++;
         check("gc_clr_excl", 32'(clear_code), 32'd0);
         check("clr_gap", 32'((cyc - last_clr) >= 2), 32'd1);
         if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
         end else begin
            check("instr", 32'(instruction_in), 32'(sb.pop_front()));
         end
      end
   end

   // Drive one byte starting at a negedge; returns at the negedge after acceptance.
   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      byte_data  = b;
      byte_valid = 1'b1;
      while (!byte_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!byte_ready) check("ready_wait", 32'd0, 32'd1);
      @(posedge clk);
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   // Full frame from fw[0..n-1]; chk_flip corrupts the checksum byte.
   task automatic send_frame(input int n, input logic [7:0] chk_flip);
      logic [7:0] cnt_b;
      logic [7:0] chk;
      cnt_b = 8'(n);
      chk   = cnt_b;
      send_byte(8'hA5);
      send_byte(cnt_b);
      for (int i = 0; i < n; i++) begin
         sb.push_back(fw[i]);
         chk = chk ^ fw[i][15:8] ^ fw[i][7:0];
         send_byte(fw[i][15:8]);
         send_byte(fw[i][7:0]);
      end
      send_byte(chk ^ chk_flip);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int gc0;
      int clr0;
      reset      = 1'b1;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_clear_code", 32'(clear_code), 32'd0);
      check("rst_getcode", 32'(getcode), 32'd0);
      check("rst_instr", 32'(instruction_in), 32'd0);
      check("rst_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
      check("rst_done", 32'(load_done), 32'd0);
      check("rst_error", 32'(load_error), 32'd0);
      check("rst_words", 32'(words_loaded), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_ready", 32'(byte_ready), 32'd1);

      // Two-word frame with good checksum.
      gc0 = gc_cnt; clr0 = clr_cnt;
      fw[0] = 16'h1234; fw[1] = 16'hABCD;
      send_frame(2, 8'h00);
      check("a_done", 32'(load_done), 32'd1);
      check("a_error", 32'(load_error), 32'd0);
      check("a_words", 32'(words_loaded), 32'd2);
      check("a_rstn_in_done", 32'(cpu_reset_n), 32'd0);
      check("a_gc_count", 32'(gc_cnt - gc0), 32'd2);
      check("a_clr_count", 32'(clr_cnt - clr0), 32'd1);
      @(negedge clk);
      check("a_rstn", 32'(cpu_reset_n), 32'd1);
      check("a_ready", 32'(byte_ready), 32'd1);

      // Same frame, checksum 43 instead of 42.
      gc0 = gc_cnt;
      send_frame(2, 8'h01);
      check("b_error", 32'(load_error), 32'd1);
      check("b_done", 32'(load_done), 32'd0);
      check("b_gc_count", 32'(gc_cnt - gc0), 32'd2);
      @(negedge clk);
      check("b_rstn", 32'(cpu_reset_n), 32'd0);

      // Garbage then a one-word frame.
      gc0 = gc_cnt; clr0 = clr_cnt;
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h5A);
      check("c_garbage_clr", 32'(clr_cnt - clr0), 32'd0);
      fw[0] = 16'h0007;
      send_frame(1, 8'h00);
      check("c_done", 32'(load_done), 32'd1);
      check("c_words", 32'(words_loaded), 32'd1);
      check("c_gc_count", 32'(gc_cnt - gc0), 32'd1);
      check("c_clr_count", 32'(clr_cnt - clr0), 32'd1);
      @(negedge clk);

      // Maximum-size frame, COUNT = 0.
      gc0 = gc_cnt;
      for (int i = 0; i < 256; i++) fw[i] = 16'(i);
      send_frame(256, 8'h00);
      check("d_done", 32'(load_done), 32'd1);
      check("d_words", 32'(words_loaded), 32'd256);
      check("d_gc_count", 32'(gc_cnt - gc0), 32'd256);
      check("d_last_instr", 32'(instruction_in), 32'h00FF);
      @(negedge clk);
      check("d_rstn", 32'(cpu_reset_n), 32'd1);

      // Stall after a HI byte until the timeout fires.
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h12);
      repeat (49) @(negedge clk);
      check("e_no_error_yet", 32'(load_error), 32'd0);
      @(negedge clk);
      check("e_error", 32'(load_error), 32'd1);
      check("e_done", 32'(load_done), 32'd0);
      check("e_rstn", 32'(cpu_reset_n), 32'd0);
      check("e_words", 32'(words_loaded), 32'd0);
      @(negedge clk);
      check("e_ready", 32'(byte_ready), 32'd1);

      // Reset during the LO byte of the third word.
      for (int i = 0; i < 4; i++) fw[i] = 16'(16'h1100 + i);
      send_byte(8'hA5);
      send_byte(8'h04);
      for (int i = 0; i < 2; i++) begin
         sb.push_back(fw[i]);
         send_byte(fw[i][15:8]);
         send_byte(fw[i][7:0]);
      end
      send_byte(fw[2][15:8]);
      check("f_words_before", 32'(words_loaded), 32'd2);
      byte_data  = fw[2][7:0];
      byte_valid = 1'b1;
      reset      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      byte_valid = 1'b0;
      reset      = 1'b0;
      check("f_getcode", 32'(getcode), 32'd0);
      check("f_instr", 32'(instruction_in), 32'd0);
      check("f_words", 32'(words_loaded), 32'd0);
      check("f_rstn", 32'(cpu_reset_n), 32'd0);
      check("f_done", 32'(load_done), 32'd0);
      check("f_error", 32'(load_error), 32'd0);
      gc0 = gc_cnt;
      @(negedge clk);
      check("f_ready", 32'(byte_ready), 32'd1);
      repeat (5) @(negedge clk);
      check("f_no_gc", 32'(gc_cnt - gc0), 32'd0);
      fw[0] = 16'hBEEF;
      send_frame(1, 8'h00);
      check("f_reload_done", 32'(load_done), 32'd1);
      check("f_reload_words", 32'(words_loaded), 32'd1);
      @(negedge clk);
      check("f_reload_rstn", 32'(cpu_reset_n), 32'd1);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
